cim_array_seq: RTL and testbench
================================

CIM_ARRAY_SEQ -- requirements
Module: cim_array_seq

Interface
REQ-001 SHALL have parameter BANKS, default 16, number of banks (2..64).
REQ-002 SHALL have parameter COLS, default 8, number of columns (2..32).
REQ-003 SHALL have parameter DW, default 16, data bus width.
REQ-004 SHALL have parameters WORD_W (default 8), the write word width, and QUERY_W (default 4), the search query width, both <= DW.
REQ-005 SHALL have parameter EXEC_CYC, default 2, cycles each array operation step is held (>= 1).
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port cmd_valid  input  1  command request.
REQ-009 SHALL have port cmd_ready  output  1  command accept; a command transfers when cmd_valid && cmd_ready at a rising edge.
REQ-010 SHALL have port op_code  input  2  00 read, 01 write, 10 search, 11 sweep-search.
REQ-011 SHALL have ports addr_bank (input, clog2(BANKS)) and addr_col (input, clog2(COLS)), giving the target bank and column.
REQ-012 SHALL have port data  input  DW  operand.
REQ-013 SHALL have ports mac_en, w_en (output, 1 each), the array enables.
REQ-014 SHALL have port data_op  output  DW  array operand.
REQ-015 SHALL have ports bank_mux (output, BANKS) and col_mux (output, COLS), one-hot or all-ones selects.
REQ-016 SHALL have ports busy, done and err (output, 1 each), giving status, a completion pulse and an address-error pulse.
REQ-017 SHALL have port col_idx  output  clog2(COLS)  active column during sweep, otherwise 0.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC and DONE, with cmd_ready = (state==IDLE) and busy = (state!=IDLE).
REQ-019 SHALL latch op_code, addresses and data on transfer; later input changes SHALL NOT affect the command in flight.
REQ-020 SHALL move IDLE->EXEC on transfer, except for an out-of-range address (addr_bank>=BANKS for op 01; addr_col>=COLS for op 10), which SHALL go IDLE->DONE with err=1 and no array selects.
REQ-021 EXEC outputs (all registered): read: bank_mux all-ones, col_mux all-ones, mac_en=1, w_en=0, data_op=data.
REQ-022 EXEC write: bank_mux one-hot at addr_bank, col_mux=0, mac_en=1, w_en=1, data_op=zero-extended data[WORD_W-1:0].
REQ-023 EXEC search: bank_mux all-ones, col_mux one-hot at addr_col, mac_en=0, w_en=0, data_op=zero-extended data[QUERY_W-1:0].
REQ-024 EXEC sweep-search: same as search, but col_idx SHALL step 0..COLS-1, holding each value for EXEC_CYC cycles, with col_mux one-hot at col_idx; addr_col is ignored.
REQ-025 EXEC SHALL last EXEC_CYC cycles (COLS*EXEC_CYC for sweep), tracked by a cycle counter and a column counter that wrap to 0 on exit.
REQ-026 DONE SHALL last exactly 1 cycle with done=1 and idle outputs, then go to IDLE.
REQ-027 Idle outputs: bank_mux=0, col_mux=0, mac_en=1, w_en=0, data_op=0, col_idx=0.
REQ-028 Timing for a transfer at edge N: EXEC outputs are valid in cycles N+1..N+EXEC_CYC, done is high in cycle N+EXEC_CYC+1, and cmd_ready is high again from cycle N+EXEC_CYC+2.
REQ-029 cmd_valid while busy SHALL be ignored and SHALL NOT be queued.
REQ-030 err SHALL pulse only together with done.

Reset
REQ-031 While rst_n=0 at a rising edge: state SHALL be IDLE, counters 0, latched command cleared, outputs at idle values, done=err=busy=0.
REQ-032 Reset asserted mid-EXEC or mid-sweep SHALL abort the command with no done pulse; cmd_ready SHALL be 1 in the first cycle after rst_n returns high.

Verification (defaults BANKS=16, COLS=8, EXEC_CYC=2)
REQ-033 Write: op 01, bank 5, data 0xABCD -> bank_mux=0x0020, w_en=1, data_op=0x00CD for 2 cycles, then done pulse, then cmd_ready=1.
REQ-034 Search: op 10, col 6, data 0x123F -> bank_mux=0xFFFF, col_mux=0x40, mac_en=0, data_op=0x000F for 2 cycles.
REQ-035 Sweep: op 11 -> col_mux=0x01,0x01,0x02,0x02,...,0x80,0x80 over 16 cycles, with col_idx tracking it, then done.
REQ-036 Back-to-back: cmd_valid held high with a changing op_code -> only commands sampled while cmd_ready=1 execute; none are lost or duplicated.
REQ-037 Reset mid-sweep at col_idx=3 -> next cycle all outputs are at idle values, done=0 and cmd_ready=1.
REQ-038 Error: BANKS=12, op 01, bank 13 -> next cycle done=1 and err=1, bank_mux=0, w_en=0.

Source files
------------

// File: rtl/cim_array_seq.sv
// -----------------------------------------------------------------------------
// cim_array_seq
// Command sequencer for a compute-in-memory array. It accepts one command at a
// time (read / write / search / sweep-search), holds each array step for
// EXEC_CYC cycles, then emits a one-cycle completion pulse before returning to
// idle. Writes to a bank that does not exist, and searches of a column that
// does not exist, skip the array entirely and complete at once with err set.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   cmd_valid  : command request
//   cmd_ready  : command accept (high only in IDLE)
//   op_code    : 00 read, 01 write, 10 search, 11 sweep-search
//   addr_bank  : target bank
//   addr_col   : target column
//   data       : command operand
//   mac_en     : array MAC enable
//   w_en       : array write enable
//   data_op    : operand presented to the array
//   bank_mux   : bank select (one-hot, all-ones or zero)
//   col_mux    : column select (one-hot, all-ones or zero)
//   busy       : sequencer not idle
//   done       : completion pulse
//   err        : address-error pulse (only together with done)
//   col_idx    : active column during sweep, otherwise 0
// All outputs are registered.
// -----------------------------------------------------------------------------
module cim_array_seq #(
    parameter int BANKS    = 16,
    parameter int COLS     = 8,
    parameter int DW       = 16,
    parameter int WORD_W   = 8,
    parameter int QUERY_W  = 4,
    parameter int EXEC_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               op_code,
    input  logic [$clog2(BANKS)-1:0] addr_bank,
    input  logic [$clog2(COLS)-1:0]  addr_col,
    input  logic [DW-1:0]            data,
    output logic                     mac_en,
    output logic                     w_en,
    output logic [DW-1:0]            data_op,
    output logic [BANKS-1:0]         bank_mux,
    output logic [COLS-1:0]          col_mux,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(COLS)-1:0]  col_idx
);

    localparam int BW  = $clog2(BANKS);
    localparam int CW  = $clog2(COLS);
    localparam int CYW = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;

    localparam logic [BW:0]    BANK_LIM = (BW+1)'(BANKS);
    localparam logic [CW:0]    COL_LIM  = (CW+1)'(COLS);
    localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);
    localparam logic [CYW-1:0] CYC_LAST = CYW'(EXEC_CYC - 1);

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_SWEEP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      op_r, op_s;
    logic [BW-1:0]   bank_r, bank_s;
    logic [CW-1:0]   col_r, col_s;
    logic [DW-1:0]   data_r, data_s;
    logic [CYW-1:0]  cyc_r, cyc_s;
    logic [CW-1:0]   colcnt_r, colcnt_s;
    logic            done_s, err_s, addr_err_s;

    logic [BANKS-1:0] bank_mux_s;
    logic [COLS-1:0]  col_mux_s;
    logic             mac_en_s, w_en_s;
    logic [DW-1:0]    data_op_s;
    logic [CW-1:0]    col_idx_s;

    function automatic logic [BANKS-1:0] bank_onehot(input logic [BW-1:0] idx);
        bank_onehot = {{(BANKS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [COLS-1:0] col_onehot(input logic [CW-1:0] idx);
        col_onehot = {{(COLS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Address range check on the incoming command; sweep ignores addr_col.
    always_comb begin
        addr_err_s = 1'b0;
        case (op_code)
            OP_WRITE:  addr_err_s = ({1'b0, addr_bank} >= BANK_LIM);
            OP_SEARCH: addr_err_s = ({1'b0, addr_col} >= COL_LIM);
            default:   addr_err_s = 1'b0;
        endcase
    end

    // Next-state, command latch and step counters.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        bank_s   = bank_r;
        col_s    = col_r;
        data_s   = data_r;
        cyc_s    = cyc_r;
        colcnt_s = colcnt_r;
        done_s   = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_s     = op_code;
                    bank_s   = addr_bank;
                    col_s    = addr_col;
                    data_s   = data;
                    cyc_s    = {CYW{1'b0}};
                    colcnt_s = {CW{1'b0}};
                    if (addr_err_s) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cyc_r == CYC_LAST) begin
                    cyc_s = {CYW{1'b0}};
                    if ((op_r == OP_SWEEP) && (colcnt_r != COL_LAST)) begin
                        colcnt_s = colcnt_r + CW'(1);
                    end else begin
                        colcnt_s = {CW{1'b0}};
                        state_s  = ST_DONE;
                        done_s   = 1'b1;
                    end
                end else begin
                    cyc_s = cyc_r + CYW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                cyc_s    = {CYW{1'b0}};
                colcnt_s = {CW{1'b0}};
            end
        endcase
    end

    // Array drive for the upcoming cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        bank_mux_s = {BANKS{1'b0}};
        col_mux_s  = {COLS{1'b0}};
        mac_en_s   = 1'b1;
        w_en_s     = 1'b0;
        data_op_s  = {DW{1'b0}};
        col_idx_s  = {CW{1'b0}};
        if (state_s == ST_EXEC) begin
            case (op_s)
                OP_READ: begin
                    bank_mux_s = {BANKS{1'b1}};
                    col_mux_s  = {COLS{1'b1}};
                    data_op_s  = data_s;
                end
                OP_WRITE: begin
                    bank_mux_s = bank_onehot(bank_s);
                    w_en_s     = 1'b1;
                    data_op_s  = DW'(data_s[WORD_W-1:0]);
                end
                OP_SEARCH: begin
                    bank_mux_s = {BANKS{1'b1}};
                    col_mux_s  = col_onehot(col_s);
                    mac_en_s   = 1'b0;
                    data_op_s  = DW'(data_s[QUERY_W-1:0]);
                end
                OP_SWEEP: begin
                    bank_mux_s = {BANKS{1'b1}};
                    col_mux_s  = col_onehot(colcnt_s);
                    mac_en_s   = 1'b0;
                    data_op_s  = DW'(data_s[QUERY_W-1:0]);
                    col_idx_s  = colcnt_s;
                end
                default: begin
                    bank_mux_s = {BANKS{1'b0}};
                end
            endcase
        end else begin
            mac_en_s = 1'b1;
        end
    end

    // State, latched command, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= 2'b00;
            bank_r    <= {BW{1'b0}};
            col_r     <= {CW{1'b0}};
            data_r    <= {DW{1'b0}};
            cyc_r     <= {CYW{1'b0}};
            colcnt_r  <= {CW{1'b0}};
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bank_mux  <= {BANKS{1'b0}};
            col_mux   <= {COLS{1'b0}};
            mac_en    <= 1'b1;
            w_en      <= 1'b0;
            data_op   <= {DW{1'b0}};
            col_idx   <= {CW{1'b0}};
        end else begin
            state_r   <= state_s;
            op_r      <= op_s;
            bank_r    <= bank_s;
            col_r     <= col_s;
            data_r    <= data_s;
            cyc_r     <= cyc_s;
            colcnt_r  <= colcnt_s;
            cmd_ready <= (state_s == ST_IDLE);
            busy      <= (state_s != ST_IDLE);
            done      <= done_s;
            err       <= err_s;
            bank_mux  <= bank_mux_s;
            col_mux   <= col_mux_s;
            mac_en    <= mac_en_s;
            w_en      <= w_en_s;
            data_op   <= data_op_s;
            col_idx   <= col_idx_s;
        end
    end

endmodule

// File: tb/tb_cim_array_seq.sv
module tb_cim_array_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid_e = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [3:0]  addr_bank = 4'd0;
    logic [2:0]  addr_col = 3'd0;
    logic [15:0] data = 16'h0000;

    logic        cmd_ready, mac_en, w_en, busy, done, err;
    logic [15:0] data_op, bank_mux;
    logic [7:0]  col_mux;
    logic [2:0]  col_idx;

    logic        cmd_ready_e, mac_en_e, w_en_e, busy_e, done_e, err_e;
    logic [15:0] data_op_e;
    logic [11:0] bank_mux_e;
    logic [7:0]  col_mux_e;
    logic [2:0]  col_idx_e;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    cim_array_seq dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .op_code(op_code), .addr_bank(addr_bank), .addr_col(addr_col), .data(data),
        .mac_en(mac_en), .w_en(w_en), .data_op(data_op), .bank_mux(bank_mux),
        .col_mux(col_mux), .busy(busy), .done(done), .err(err), .col_idx(col_idx)
    );

    cim_array_seq #(.BANKS(12)) dut_e (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_e), .cmd_ready(cmd_ready_e),
        .op_code(op_code), .addr_bank(addr_bank), .addr_col(addr_col), .data(data),
        .mac_en(mac_en_e), .w_en(w_en_e), .data_op(data_op_e), .bank_mux(bank_mux_e),
        .col_mux(col_mux_e), .busy(busy_e), .done(done_e), .err(err_e), .col_idx(col_idx_e)
    );

    // Status bundle {cmd_ready, busy, done, err, mac_en, w_en}
    function automatic logic [5:0] st();
        st = {cmd_ready, busy, done, err, mac_en, w_en};
    endfunction

    // Drive one command so that it transfers at the next rising edge, then
    // scramble the inputs to show the command in flight is latched.
    task automatic issue(input logic [1:0] op, input logic [3:0] b, input logic [2:0] c,
                         input logic [15:0] d, input logic to_e);
        @(negedge clk);
        op_code = op; addr_bank = b; addr_col = c; data = d;
        if (to_e) cmd_valid_e = 1'b1; else cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_valid_e = 1'b0;
        op_code = ~op; addr_bank = ~b; addr_col = ~c; data = ~d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if (st() !== 6'b100010) $display("FAIL reset_status got=%b exp=%b", st(), 6'b100010);
        else pass_cnt++;
        chk_cnt++;
        if ({bank_mux, col_mux, data_op, col_idx} !== 43'd0)
            $display("FAIL reset_outputs got=%h/%h/%h/%h exp=0", bank_mux, col_mux, data_op, col_idx);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        issue(2'b01, 4'd5, 3'd0, 16'hABCD, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({bank_mux, col_mux, data_op} !== {16'h0020, 8'h00, 16'h00CD})
                $display("FAIL write_exec%0d got=%h/%h/%h exp=0020/00/00cd", i, bank_mux, col_mux, data_op);
            else pass_cnt++;
            chk_cnt++;
            if (st() !== 6'b010011) $display("FAIL write_status%0d got=%b exp=%b", i, st(), 6'b010011);
            else pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++;
        if (st() !== 6'b011010 || bank_mux !== 16'h0000 || data_op !== 16'h0000)
            $display("FAIL write_done got=%b/%h/%h exp=%b/0000/0000", st(), bank_mux, data_op, 6'b011010);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (st() !== 6'b100010) $display("FAIL write_ready got=%b exp=%b", st(), 6'b100010);
        else pass_cnt++;
    endtask

    task automatic test_read();
        issue(2'b00, 4'd2, 3'd1, 16'h5A5A, 1'b0);
        @(negedge clk);
        chk_cnt++;
        if ({bank_mux, col_mux, data_op, mac_en, w_en} !== {16'hFFFF, 8'hFF, 16'h5A5A, 1'b1, 1'b0})
            $display("FAIL read_exec got=%h/%h/%h/%b%b exp=ffff/ff/5a5a/10", bank_mux, col_mux, data_op, mac_en, w_en);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (st() !== 6'b100010) $display("FAIL read_ready got=%b exp=%b", st(), 6'b100010);
        else pass_cnt++;
    endtask

    task automatic test_search();
        issue(2'b10, 4'd0, 3'd6, 16'h123F, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({bank_mux, col_mux, data_op, mac_en, w_en, col_idx} !== {16'hFFFF, 8'h40, 16'h000F, 1'b0, 1'b0, 3'd0})
                $display("FAIL search_exec%0d got=%h/%h/%h/%b%b/%0d exp=ffff/40/000f/00/0",
                         i, bank_mux, col_mux, data_op, mac_en, w_en, col_idx);
            else pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++;
        if (done !== 1'b1 || col_mux !== 8'h00) $display("FAIL search_done got=%b/%h exp=1/00", done, col_mux);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [7:0] exp_col;
        issue(2'b11, 4'd0, 3'd5, 16'hFFF9, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_col = 8'h01 << (i / 2);
            chk_cnt++;
            if (col_mux !== exp_col || col_idx !== 3'(i / 2) || bank_mux !== 16'hFFFF ||
                data_op !== 16'h0009 || done !== 1'b0)
                $display("FAIL sweep_step%0d got=%h/%0d/%h/%h/%b exp=%h/%0d/ffff/0009/0",
                         i, col_mux, col_idx, bank_mux, data_op, done, exp_col, i / 2);
            else pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++;
        if (done !== 1'b1 || col_idx !== 3'd0 || col_mux !== 8'h00)
            $display("FAIL sweep_done got=%b/%0d/%h exp=1/0/00", done, col_idx, col_mux);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL sweep_ready got=%b exp=1", cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        issue(2'b11, 4'd0, 3'd0, 16'h0003, 1'b0);
        repeat (7) @(negedge clk);
        chk_cnt++;
        if (col_idx !== 3'd3) $display("FAIL rst_sweep_pos got=%0d exp=3", col_idx);
        else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_cnt++;
        if (st() !== 6'b100010 || {bank_mux, col_mux, data_op, col_idx} !== 43'd0)
            $display("FAIL rst_sweep_idle got=%b/%h/%h/%h/%0d exp=%b/0/0/0/0",
                     st(), bank_mux, col_mux, data_op, col_idx, 6'b100010);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (st() !== 6'b100010) $display("FAIL rst_sweep_after got=%b exp=%b", st(), 6'b100010);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [12];
        int dones;
        ops = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        dones = 0;
        @(negedge clk);
        addr_bank = 4'd3; addr_col = 3'd2; data = 16'h0F0F;
        cmd_valid = 1'b1; op_code = ops[0];
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (j == 1) begin
                chk_cnt++;
                if ({bank_mux, w_en, data_op} !== {16'h0008, 1'b1, 16'h000F})
                    $display("FAIL b2b_write got=%h/%b/%h exp=0008/1/000f", bank_mux, w_en, data_op);
                else pass_cnt++;
            end else if (j == 5) begin
                chk_cnt++;
                if ({col_mux, mac_en, data_op} !== {8'h04, 1'b0, 16'h000F})
                    $display("FAIL b2b_search got=%h/%b/%h exp=04/0/000f", col_mux, mac_en, data_op);
                else pass_cnt++;
            end else if (j == 9) begin
                chk_cnt++;
                if ({bank_mux, col_mux, data_op} !== {16'hFFFF, 8'hFF, 16'h0F0F})
                    $display("FAIL b2b_read got=%h/%h/%h exp=ffff/ff/0f0f", bank_mux, col_mux, data_op);
                else pass_cnt++;
            end else if (j == 2 || j == 6 || j == 10) begin
                chk_cnt++;
                if (cmd_ready !== 1'b0) $display("FAIL b2b_busy%0d got=%b exp=0", j, cmd_ready);
                else pass_cnt++;
            end else begin
                if (j % 4 == 0) begin
                    chk_cnt++;
                    if (cmd_ready !== 1'b1) $display("FAIL b2b_ready%0d got=%b exp=1", j, cmd_ready);
                    else pass_cnt++;
                end
            end
            if (j < 12) op_code = ops[j];
            else cmd_valid = 1'b0;
        end
        chk_cnt++;
        if (dones != 3) $display("FAIL b2b_done_count got=%0d exp=3", dones);
        else pass_cnt++;
    endtask

    task automatic test_error();
        issue(2'b01, 4'd13, 3'd0, 16'h00AA, 1'b1);
        @(negedge clk);
        chk_cnt++;
        if ({done_e, err_e, bank_mux_e, w_en_e} !== {1'b1, 1'b1, 12'h000, 1'b0})
            $display("FAIL err_pulse got=%b/%b/%h/%b exp=1/1/000/0", done_e, err_e, bank_mux_e, w_en_e);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({cmd_ready_e, done_e, err_e} !== 3'b100)
            $display("FAIL err_after got=%b exp=100", {cmd_ready_e, done_e, err_e});
        else pass_cnt++;
        issue(2'b01, 4'd11, 3'd0, 16'h0077, 1'b1);
        @(negedge clk);
        chk_cnt++;
        if ({bank_mux_e, w_en_e, data_op_e} !== {12'h800, 1'b1, 16'h0077})
            $display("FAIL err_inrange got=%h/%b/%h exp=800/1/0077", bank_mux_e, w_en_e, data_op_e);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({done_e, err_e} !== 2'b10) $display("FAIL err_inrange_done got=%b exp=10", {done_e, err_e});
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_search();
        test_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        test_error();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
